// File: rtl/pipeline_control.sv
// pipeline_control: S-stage full-bit stall engine, decode-stage forwarding
// select with load-use detection, per-stage flush and stall-cycle counter.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   struct_hazard       fetch must hold this cycle
//   rs, rt, rs_used,    decode-stage source addresses and use flags
//   rt_used
//   we_vec, cad_vec,    per-stage write enable, destination address,
//   avail_vec           and "result already present" flag
//   flush_mask          empty the marked stages at the next edge
//   full, ue, stall     per-stage valid, update enable, hold
//   fwd_a, fwd_b        forwarding select (0 = GPR, d = stage ID+d)
//   hazard_a, hazard_b  operand value not yet available
//   stall_cycles        saturating count of cycles with stall[0]
module pipeline_control #(
    parameter int S  = 5,
    parameter int ID = 1,
    parameter int AW = 5,
    parameter int FW = 3,
    parameter int CW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            struct_hazard,
    input  logic [AW-1:0]   rs,
    input  logic [AW-1:0]   rt,
    input  logic            rs_used,
    input  logic            rt_used,
    input  logic [S-1:0]    we_vec,
    input  logic [S*AW-1:0] cad_vec,
    input  logic [S-1:0]    avail_vec,
    input  logic [S-1:0]    flush_mask,
    output logic [S-1:0]    full,
    output logic [S-1:0]    ue,
    output logic [S-1:0]    stall,
    output logic [FW-1:0]   fwd_a,
    output logic [FW-1:0]   fwd_b,
    output logic            hazard_a,
    output logic            hazard_b,
    output logic [CW-1:0]   stall_cycles
);

    logic [S-1:0] match_a;
    logic [S-1:0] match_b;
    logic [S-1:0] haz;
    logic [S-1:0] full_nxt;
    logic         found_a;
    logic         found_b;

    // A stage is a forwarding candidate only if it is downstream of decode,
    // holds a valid instruction, writes a GPR and targets a nonzero source.
    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int k = 0; k < S; k++) begin
            if (k > ID) begin
                match_a[k] = full[k] && we_vec[k] &&
                             (cad_vec[k*AW +: AW] == rs) && (rs != '0);
                match_b[k] = full[k] && we_vec[k] &&
                             (cad_vec[k*AW +: AW] == rt) && (rt != '0);
            end
        end
    end

    // The nearest downstream stage holds the youngest producer; only its
    // availability matters, older ready values never hide it.
    always_comb begin
        fwd_a    = '0;
        hazard_a = 1'b0;
        found_a  = 1'b0;
        for (int j = ID + 1; j < S; j++) begin
            if (match_a[j] && !found_a) begin
                found_a  = 1'b1;
                fwd_a    = rs_used ? FW'(j - ID) : '0;
                hazard_a = rs_used && !avail_vec[j];
            end
        end
    end

    always_comb begin
        fwd_b    = '0;
        hazard_b = 1'b0;
        found_b  = 1'b0;
        for (int j = ID + 1; j < S; j++) begin
            if (match_b[j] && !found_b) begin
                found_b  = 1'b1;
                fwd_b    = rt_used ? FW'(j - ID) : '0;
                hazard_b = rt_used && !avail_vec[j];
            end
        end
    end

    always_comb begin
        haz     = '0;
        haz[0]  = struct_hazard;
        haz[ID] = hazard_a | hazard_b;
    end

    // A full stage holds if it has a hazard itself or the stage after it
    // holds; walk from writeback toward fetch carrying the hold.
    always_comb begin
        logic run;
        run   = 1'b0;
        stall = '0;
        for (int k = S - 1; k >= 0; k--) begin
            run      = full[k] && (haz[k] || run);
            stall[k] = run;
        end
    end

    assign ue = rst ? '0 : (full & ~stall);

    // Flush wins over hold: a held, flushed stage becomes a bubble.
    always_comb begin
        full_nxt    = '0;
        full_nxt[0] = 1'b1;
        for (int k = 1; k < S; k++) begin
            full_nxt[k] = !flush_mask[k] && (ue[k-1] || stall[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full         <= S'(1);
            stall_cycles <= '0;
        end else begin
            full <= full_nxt;
            if (stall[0] && !(&stall_cycles)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_control.sv
// tb_pipeline_control: directed test-plan scenarios plus randomized traffic,
// every cycle compared against an instruction-level model of the pipeline.
module tb_pipeline_control;

    localparam int S  = 5;
    localparam int ID = 1;
    localparam int AW = 5;
    localparam int FW = 3;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            struct_hazard;
    logic [AW-1:0]   rs, rt;
    logic            rs_used, rt_used;
    logic [S-1:0]    we_vec;
    logic [S*AW-1:0] cad_vec;
    logic [S-1:0]    avail_vec;
    logic [S-1:0]    flush_mask;
    logic [S-1:0]    full, ue, stall;
    logic [FW-1:0]   fwd_a, fwd_b;
    logic            hazard_a, hazard_b;
    logic [CW-1:0]   stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    logic [S-1:0] mfull = '0;
    int           mcnt  = 0;
    logic         armed = 1'b0;

    always #5 clk = ~clk;

    pipeline_control #(
        .S(S), .ID(ID), .AW(AW), .FW(FW), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .struct_hazard(struct_hazard),
        .rs(rs), .rt(rt), .rs_used(rs_used), .rt_used(rt_used),
        .we_vec(we_vec), .cad_vec(cad_vec), .avail_vec(avail_vec),
        .flush_mask(flush_mask), .full(full), .ue(ue), .stall(stall),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .hazard_a(hazard_a),
        .hazard_b(hazard_b), .stall_cycles(stall_cycles)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Youngest producer of r among the stages after decode, -1 if none.
    function automatic int youngest(input logic [AW-1:0] r);
        if (r == '0) return -1;
        for (int j = ID + 1; j < S; j++)
            if (mfull[j] && we_vec[j] && cad_vec[j*AW +: AW] == r)
                return j;
        return -1;
    endfunction

    function automatic void model(output logic [S-1:0] e_st,
                                  output logic [S-1:0] e_ue,
                                  output logic [FW-1:0] e_fa,
                                  output logic [FW-1:0] e_fb,
                                  output logic e_ha, output logic e_hb);
        int ja, jb;
        bit hz;
        ja   = youngest(rs);
        jb   = youngest(rt);
        e_fa = (ja > 0 && rs_used) ? FW'(ja - ID) : '0;
        e_fb = (jb > 0 && rt_used) ? FW'(jb - ID) : '0;
        e_ha = ja > 0 && rs_used && !avail_vec[ja];
        e_hb = jb > 0 && rt_used && !avail_vec[jb];
        // A stage holds if some stage at or after it has a hazard and
        // every stage in between is occupied.
        for (int k = 0; k < S; k++) begin
            e_st[k] = 1'b0;
            for (int m = k; m < S; m++) begin
                if (!mfull[m]) break;
                hz = (m == 0 && struct_hazard) ||
                     (m == ID && (e_ha || e_hb));
                if (hz) begin
                    e_st[k] = 1'b1;
                    break;
                end
            end
            e_ue[k] = !rst && mfull[k] && !e_st[k];
        end
    endfunction

    function automatic logic [S-1:0] next_full();
        logic [S-1:0] st, u, nf;
        logic [FW-1:0] fa, fb;
        logic ha, hb;
        model(st, u, fa, fb, ha, hb);
        if (rst) return S'(1);
        nf[0] = 1'b1;
        for (int k = 1; k < S; k++) begin
            if (flush_mask[k])      nf[k] = 1'b0;
            else if (st[k])         nf[k] = 1'b1;
            else                    nf[k] = mfull[k-1] && !st[k-1];
        end
        return nf;
    endfunction

    function automatic int next_cnt();
        logic [S-1:0] st, u;
        logic [FW-1:0] fa, fb;
        logic ha, hb;
        model(st, u, fa, fb, ha, hb);
        if (rst) return 0;
        if (st[0] && mcnt < CMAX) return mcnt + 1;
        return mcnt;
    endfunction

    always @(posedge clk) begin
        mfull <= next_full();
        mcnt  <= next_cnt();
        if (rst) armed <= 1'b1;
    end

    always @(negedge clk) begin
        logic [S-1:0] e_st, e_ue;
        logic [FW-1:0] e_fa, e_fb;
        logic e_ha, e_hb;
        if (armed) begin
            model(e_st, e_ue, e_fa, e_fb, e_ha, e_hb);
            check("m_full", 32'(full), 32'(mfull));
            check("m_stall", 32'(stall), 32'(e_st));
            check("m_ue", 32'(ue), 32'(e_ue));
            check("m_fwd_a", 32'(fwd_a), 32'(e_fa));
            check("m_fwd_b", 32'(fwd_b), 32'(e_fb));
            check("m_haz_a", 32'(hazard_a), 32'(e_ha));
            check("m_haz_b", 32'(hazard_b), 32'(e_hb));
            check("m_cnt", 32'(stall_cycles), 32'(mcnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        struct_hazard = 1'b0;
        rs = '0; rt = '0;
        rs_used = 1'b0; rt_used = 1'b0;
        we_vec = '0; cad_vec = '0;
        avail_vec = '0; flush_mask = '0;
    endtask

    task automatic refill();
        clr();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
    endtask

    task automatic load_at(input int stg, input logic av);
        we_vec = '0;
        cad_vec = '0;
        avail_vec = '0;
        we_vec[stg] = 1'b1;
        cad_vec[stg*AW +: AW] = AW'(8);
        avail_vec[stg] = av;
        rs = AW'(8);
        rs_used = 1'b1;
    endtask

    logic [S-1:0] fill_exp [6] = '{5'b00001, 5'b00011, 5'b00111,
                                   5'b01111, 5'b11111, 5'b11111};

    initial begin
        clr();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("fill_full", 32'(full), 32'(fill_exp[i]));
            check("fill_ue", 32'(ue), 32'(fill_exp[i]));
            check("fill_cnt", 32'(stall_cycles), 0);
            tick();
        end

        load_at(2, 1'b0);
        @(negedge clk);
        check("lu_haz_a", 32'(hazard_a), 1);
        check("lu_stall", 32'(stall), 32'(5'b00011));
        check("lu_fwd_a", 32'(fwd_a), 1);
        tick();
        load_at(3, 1'b1);
        @(negedge clk);
        check("lu_full", 32'(full), 32'(5'b11011));
        check("lu_fwd2", 32'(fwd_a), 2);
        check("lu_nohaz", 32'(hazard_a), 0);
        check("lu_cnt", 32'(stall_cycles), 1);
        tick();
        clr();
        tick();
        tick();

        we_vec = 5'b01100;
        avail_vec = 5'b01100;
        cad_vec[2*AW +: AW] = AW'(5);
        cad_vec[3*AW +: AW] = AW'(5);
        rt = AW'(5);
        rt_used = 1'b1;
        @(negedge clk);
        check("fw_full", 32'(full), 32'(5'b11111));
        check("fw_young", 32'(fwd_b), 1);
        check("fw_nohaz", 32'(hazard_b), 0);
        #2;
        rt = '0;
        #1;
        check("fw_r0", 32'(fwd_b), 0);
        check("fw_r0haz", 32'(hazard_b), 0);
        tick();

        refill();
        struct_hazard = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sh_stall", 32'(stall), 32'(5'b00001));
            if (i > 0) check("sh_bubble", 32'(full[1]), 0);
            tick();
        end
        struct_hazard = 1'b0;
        @(negedge clk);
        check("sh_full", 32'(full), 32'(5'b10001));
        check("sh_cnt", 32'(stall_cycles), 3);

        refill();
        load_at(2, 1'b0);
        flush_mask = 5'b00010;
        @(negedge clk);
        check("fl_stall", 32'(stall), 32'(5'b00011));
        tick();
        load_at(3, 1'b1);
        flush_mask = '0;
        @(negedge clk);
        check("fl_full", 32'(full), 32'(5'b11001));
        check("fl_stall0", 32'(stall), 0);
        tick();

        clr();
        struct_hazard = 1'b1;
        repeat (20) tick();
        @(negedge clk);
        check("sat_cnt", 32'(stall_cycles), 32'(CMAX));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_full", 32'(full), 32'(5'b00001));
        check("rst_cnt", 32'(stall_cycles), 0);
        tick();

        repeat (3000) begin
            rst = ($urandom_range(0, 63) == 0);
            struct_hazard = ($urandom_range(0, 7) == 0);
            rs = AW'($urandom_range(0, 3));
            rt = AW'($urandom_range(0, 3));
            rs_used = 1'($urandom);
            rt_used = 1'($urandom);
            we_vec = S'($urandom);
            avail_vec = S'($urandom);
            for (int k = 0; k < S; k++)
                cad_vec[k*AW +: AW] = AW'($urandom_range(0, 3));
            flush_mask = ($urandom_range(0, 7) == 0) ? S'($urandom) : '0;
            tick();
        end
        clr();
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_control.md
# pipeline_control

Parametrised pipeline control for the pipelined MIPS core: an S-stage full-bit stall engine, decode-stage operand forwarding selection with load-use hazard detection, per-stage flush and a stall-cycle performance counter. It replaces the fixed five-stage stall engine and the fixed two-source forwarding unit with one block. The core's per-stage register enables (`ue`), its forwarding muxes in decode, and its full-bit debug LEDs are driven from here.

## Interface
- `S`, 5, number of pipeline stages (stage 0 = fetch, S-1 = writeback); legal 3..8
- `ID`, 1, index of the decode stage (operand read and forwarding point); 0 < ID < S-1
- `AW`, 5, register address width
- `FW`, 3, forwarding select width; must satisfy 2^FW > S-1-ID
- `CW`, 32, stall counter width

Ports:
- `clk`  in  1  sole clock, all state rises on posedge
- `rst`  in  1  synchronous, active-high reset
- `struct_hazard`  in  1  fetch must not advance this cycle (shared memory port used by a load/store)
- `rs`, `rt`  in  AW each  decode-stage source register addresses
- `rs_used`, `rt_used`  in  1 each  decode instruction actually reads rs / rt
- `we_vec`  in  S  per-stage "instruction writes a GPR"; bit k belongs to stage k
- `cad_vec`  in  S*AW  per-stage destination address; stage k at bits [k*AW +: AW]
- `avail_vec`  in  S  per-stage "result value already present at stage output"
- `flush_mask`  in  S  clear the full bit of the marked stages at the next edge; bit 0 ignored
- `full`  out  S  stage k holds a valid instruction
- `ue`  out  S  update enable of the register set feeding stage k+1 (bit S-1: GPR write enable qualifier)
- `stall`  out  S  stage k holds its instruction this cycle
- `fwd_a`, `fwd_b`  out  FW each  0 = GPR read data; d>0 = value from stage ID+d
- `hazard_a`, `hazard_b`  out  1 each  operand needs a value not yet available
- `stall_cycles`  out  CW  saturating count of cycles with `stall[0]`=1

## Operation
- State: `full` register (S bits) and `stall_cycles` counter; all else combinational.
- Hazard per stage: `haz[0]` = `struct_hazard`; `haz[ID]` = `hazard_a | hazard_b`; all other `haz[k]` = 0.
- Stall chain, evaluated from k = S-1 down to 0: `stall[k]` = `full[k] & (haz[k] | stall[k+1])`, with `stall[S]` = 0.
- `ue[k]` = `full[k] & ~stall[k]`; forced to 0 while `rst`=1.
- Next full: `full[0]` ← 1; for k ≥ 1, `full[k]` ← 0 if `flush_mask[k]`, else `ue[k-1] | stall[k]`.
- Flush overrides stall: a stalled, flushed stage becomes empty; upstream stages are unaffected by a downstream flush.
- Forwarding, operand a (b identical with rt/rt_used): candidate stages j in ID+1..S-1 where `full[j] & we_vec[j] & cad_j == rs & rs != 0`. Pick the smallest j (youngest instruction). `fwd_a` = j-ID if found and `rs_used`, else 0.
- `hazard_a` = `rs_used & found & ~avail_vec[j]` for the selected j only; an older stage with a ready value never masks a younger unready one.
- Empty stages (`full[j]`=0) never match. Register 0 never matches and never hazards.
- `stall_cycles` increments when `stall[0]`=1 and it is below 2^CW-1; holds at all ones.

## Timing
- Reset (`rst`=1 at edge): `full` ← 0…01, `stall_cycles` ← 0. During reset, `ue` = 0; `stall`, `fwd_*` and `hazard_*` follow the combinational rules.
- First cycle after reset: only fetch full; instruction reaches stage k k cycles later if no stalls.
- All outputs except `full` and `stall_cycles` are combinational from the current inputs and `full`. There is no registered latency.
- Load-use: a load in stage ID+1 with `avail`=0 stalls decode and fetch for exactly one cycle. The bubble enters ID+1 (full[ID+1]=0) and the load moves to ID+2, which then forwards with `fwd`=2.
- `struct_hazard` stalls only stage 0. `full[1]` goes 0 on the next edge (bubble) unless `flush_mask[1]` is also set, in which case `full[1]` is still 0.
- Reset asserted mid-stall: the next edge restores the reset values; no partial state survives.

## Test plan
- Reset then 6 idle cycles, no hazards, S=5 → `full` = 00001, 00011, 00111, 01111, 11111, 11111; `ue` = `full`; `stall_cycles`=0.
- Full pipe, stage 2 load `we`=1 `cad`=8 `avail`=0, decode `rs`=8 `rs_used` → `hazard_a`=1, `stall`=00011, next edge `full`=11011, then `fwd_a`=2, `hazard_a`=0.
- Stage 2 and stage 3 both write r5, both avail, `rt`=5 → `fwd_b`=1; same with `rt`=0 → `fwd_b`=0, `hazard_b`=0.
- `struct_hazard`=1 for 3 cycles on a full pipe → `stall`=00001 each cycle, `full[1]`=0 after first edge, `stall_cycles`=3.
- During a load-use stall assert `flush_mask`=00010 → next edge `full[1]`=0 and `full[2]`=0; fetch stays full; stall clears.
- CW=4, hold `struct_hazard`=1 for 20 cycles → `stall_cycles` stops at 15; pulse `rst` → 0 and `full`=00001 next cycle.
